fp32_stim_gen: RTL and testbench
================================

# fp32_stim_gen

Stimulus source for the fp32 adder testbench: produces the operand pairs `x1`/`x2` with a `val` qualifier, and ends the run with a single-cycle `over` pulse. It drives both the adder's inputs and the inputs of the result checker, which delays them by the adder's 5-cycle pipeline. It issues an optional directed corner-case sequence, then a seeded pseudo-random sequence of finite operands. It supports pausing via `hold`.

## Interface
- `NUM_RANDOM`, default 100000: number of random vectors issued after the corner phase; 32-bit, must be ≥1.
- `SEED`, default 32'h1ACE_B00C: seed for LFSR A. LFSR B uses `SEED ^ 32'hA5A5_A5A5`. A zero seed is replaced by 32'h1.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request, sampled only in IDLE.
- `hold`  in  1  pause; while high, no vector is issued and all state is frozen.
- `x1`  out  32  operand 1, IEEE-754 single.
- `x2`  out  32  operand 2, IEEE-754 single.
- `val`  out  1  `x1`/`x2` valid this cycle.
- `over`  out  1  end-of-run pulse.

## Operation
- FSM states: IDLE, CORNER, RANDOM, DONE.
- IDLE → CORNER when `en`=1 (with `STIM_CORNER_EN`); otherwise IDLE → RANDOM.
- CORNER issues table entries 0..15 in order, one per non-held cycle. After entry 15 it moves to RANDOM.
- RANDOM issues one vector per non-held cycle.
  - `x1` = LFSR A state; `x2` = LFSR B state.
  - If bits [30:23] of an operand equal 8'hFF, they are forced to 8'hFE. No NaN or Inf is ever issued.
  - Both LFSRs advance after each issued vector.
- Vector count: a 32-bit counter. After `NUM_RANDOM` random vectors the FSM moves to DONE.
- DONE: `over`=1 for exactly one cycle on entry, then 0. DONE is terminal; `en` is ignored until reset.
- LFSRs: 32-bit Galois, right-shift, feedback mask 32'h8020_0003. If lsb=1, next = (s>>1)^mask; otherwise next = s>>1.
- `hold`:
  - `val`=0.
  - `x1`/`x2` keep their last value.
  - FSM, counters and LFSRs are frozen.
  - `hold` has no effect in IDLE or DONE.
  - If `hold` and the DONE transition coincide, the transition waits until `hold` falls.
- Corner table (x1, x2):
  - 0: 0000_0000, 0000_0000
  - 1: 3F80_0000, 3F80_0000
  - 2: 3F80_0000, BF80_0000
  - 3: 7F7F_FFFF, 7F7F_FFFF
  - 4: 0000_0001, 0000_0001
  - 5: 0080_0000, 8000_0001
  - 6: 4B80_0000, 3F80_0000
  - 7: 3F80_0000, 3380_0000
  - 8: 8000_0000, 0000_0000
  - 9: 3FFF_FFFF, 3400_0000
  - 10: C120_0000, 4120_0000
  - 11: 007F_FFFF, 0000_0001
  - 12: 4F00_0000, CEFF_FFFF
  - 13: 3F80_0001, BF80_0000
  - 14: 7F00_0000, 7F00_0000
  - 15: 3EAA_AAAB, 3F2A_AAAB

## Timing
- All outputs are registered. Reset values: `x1`=0, `x2`=0, `val`=0, `over`=0. FSM resets to IDLE, LFSRs to their seeds, counters to 0.
- If `en` is sampled high in IDLE at edge N, the first vector appears with `val`=1 after edge N+1.
- With `hold`=0 throughout, `val` is high for exactly 16·(corner enabled)+`NUM_RANDOM` consecutive cycles.
- `over` rises in the cycle immediately after the last valid vector, with `val`=0. The checker delays `over` by 5, so the run ends after the last result has been checked.
- `hold` asserted at edge N: the cycle after edge N has `val`=0. `hold` deasserted at edge M: the next vector follows edge M+1.
- Reset asserted mid-run: all state clears immediately, asynchronously. After release the generator is in IDLE, and the sequence is identical to the first run.

## Configuration
- `STIM_CORNER_EN` defined: the CORNER state and the 16-entry table are compiled in.
- `STIM_CORNER_EN` not defined: the table and the CORNER state are absent, IDLE goes directly to RANDOM, and the total vector count is `NUM_RANDOM`.

## Structure
- Shared package `fp32_tb_pkg` contains:
  - the state enum `stim_state_t`;
  - `ADDER_LATENCY`=5;
  - `LFSR_MASK`=32'h8020_0003;
  - `SEED_XOR`=32'hA5A5_A5A5;
  - the corner table as a localparam array of 16 {x1, x2} pairs;
  - the function `fp32_sanitize()` that forces the 8'hFF exponent to 8'hFE.
- Sub-module `fp32_lfsr32` (parameter SEED; ports `clk`, `rst`, `adv`, `q`) is instantiated twice.

## Test plan
- Reset, then `en`=1 with corner enabled → after 1 cycle, vector 0 = {0000_0000, 0000_0000}; vector 1 = {3F80_0000, 3F80_0000}; vector 15 = {3EAA_AAAB, 3F2A_AAAB}.
- `NUM_RANDOM`=4, `SEED`=32'h1 → random vector 0 `x1`=0000_0001; LFSR A's next state = 8020_0003. Exactly 20 `val` cycles, then one `over` pulse.
- Seed that produces exponent FF (force LFSR state 7F80_0000) → issued `x1`=7F00_0000.
- `hold`=1 for 3 cycles mid-CORNER at entry 5 → `val`=0 for 3 cycles, then entry 5 (not 6) appears; the total count is unchanged.
- Reset asserted during RANDOM at vector 2 → outputs are 0 immediately. After release and `en`, the sequence is bit-identical to the first run.
- `SEED`=0 → LFSR A starts at 32'h1; `over` is never asserted before the final valid vector.

Source files
------------

// File: rtl/fp32_tb_pkg.sv
// Shared types and constants for the fp32 adder stimulus source.
// The corner-case table exists only when STIM_CORNER_EN is defined.
package fp32_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CORNER = 2'd1,
        ST_RANDOM = 2'd2,
        ST_DONE   = 2'd3
    } stim_state_t;

    // Pipeline depth of the adder; the result checker delays stimulus by this much.
    localparam int          ADDER_LATENCY = 5;
    localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;
    localparam logic [31:0] SEED_XOR      = 32'hA5A5_A5A5;

`ifdef STIM_CORNER_EN
    // Directed operand pairs, {x1, x2}, issued in index order.
    localparam logic [63:0] CORNER_TBL [0:15] = '{
        {32'h0000_0000, 32'h0000_0000},
        {32'h3F80_0000, 32'h3F80_0000},
        {32'h3F80_0000, 32'hBF80_0000},
        {32'h7F7F_FFFF, 32'h7F7F_FFFF},
        {32'h0000_0001, 32'h0000_0001},
        {32'h0080_0000, 32'h8000_0001},
        {32'h4B80_0000, 32'h3F80_0000},
        {32'h3F80_0000, 32'h3380_0000},
        {32'h8000_0000, 32'h0000_0000},
        {32'h3FFF_FFFF, 32'h3400_0000},
        {32'hC120_0000, 32'h4120_0000},
        {32'h007F_FFFF, 32'h0000_0001},
        {32'h4F00_0000, 32'hCEFF_FFFF},
        {32'h3F80_0001, 32'hBF80_0000},
        {32'h7F00_0000, 32'h7F00_0000},
        {32'h3EAA_AAAB, 32'h3F2A_AAAB}
    };
`endif

    // Pull an all-ones exponent down by one so no NaN/Inf is ever issued.
    function automatic logic [31:0] fp32_sanitize(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        if (v[30:23] == 8'hFF) begin
            r[30:23] = 8'hFE;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_stim_gen_if.sv
// Operand bus from the stimulus source to the adder and the result checker.
// Handshake: there is no ready; x1/x2 are consumed on every cycle where val=1,
// and hold (a plain input of the source) is the only backpressure. over is a
// single-cycle end-of-run pulse that never coincides with val.
interface fp32_stim_gen_if;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        val;
    logic        over;

    modport master (output x1, output x2, output val, output over);
    modport slave  (input  x1, input  x2, input  val, input  over);
endinterface

// File: rtl/fp32_lfsr32.sv
// 32-bit right-shifting Galois LFSR; steps once per cycle with adv high.
// A zero seed would lock up, so it is replaced by 1.
module fp32_lfsr32
    import fp32_tb_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [31:0] q
);

    localparam logic [31:0] START = (SEED == 32'h0) ? 32'h1 : SEED;

    // Shift state right, folding the feedback mask in when the lsb falls out as 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= START;
        end else if (adv) begin
            q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
        end
    end

endmodule

// File: rtl/fp32_stim_gen.sv
// Stimulus source for the fp32 adder bench: optional directed corner phase,
// then NUM_RANDOM pseudo-random finite operand pairs, then one over pulse.
// Build option: define STIM_CORNER_EN to compile in the corner table/state.
module fp32_stim_gen
    import fp32_tb_pkg::*;
#(
    parameter logic [31:0] NUM_RANDOM = 32'd100000,
    parameter logic [31:0] SEED       = 32'h1ACE_B00C
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   hold,
    fp32_stim_gen_if.master        stim,
    output stim_state_t            state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
`ifdef STIM_CORNER_EN
    localparam logic [1:0] CORNER = 2'd1;
`endif
    localparam logic [1:0] RANDOM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  state;
    logic [31:0] cnt;
    logic        over_sent;
    logic [31:0] x1_r;
    logic [31:0] x2_r;
    logic        val_r;
    logic        over_r;
    logic [31:0] lfsr_a_q;
    logic [31:0] lfsr_b_q;
    logic        lfsr_adv;
`ifdef STIM_CORNER_EN
    logic [3:0]  idx;
`endif

    // LFSRs step only when a random vector is actually issued.
    assign lfsr_adv = (state == RANDOM) && !hold;

    fp32_lfsr32 #(.SEED(SEED)) u_lfsr_a (
        .clk (clk),
        .rst (rst),
        .adv (lfsr_adv),
        .q   (lfsr_a_q)
    );

    fp32_lfsr32 #(.SEED(SEED ^ SEED_XOR)) u_lfsr_b (
        .clk (clk),
        .rst (rst),
        .adv (lfsr_adv),
        .q   (lfsr_b_q)
    );

    // Sequencer: issue one vector per non-held cycle, pulse over once at the end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            over_sent <= 1'b0;
            x1_r      <= 32'd0;
            x2_r      <= 32'd0;
            val_r     <= 1'b0;
            over_r    <= 1'b0;
`ifdef STIM_CORNER_EN
            idx       <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    val_r  <= 1'b0;
                    over_r <= 1'b0;
                    if (en) begin
`ifdef STIM_CORNER_EN
                        state <= CORNER;
`else
                        state <= RANDOM;
`endif
                    end
                end
`ifdef STIM_CORNER_EN
                CORNER: begin
                    if (hold) begin
                        val_r <= 1'b0;
                    end else begin
                        {x1_r, x2_r} <= CORNER_TBL[idx];
                        val_r        <= 1'b1;
                        idx          <= idx + 4'd1;
                        if (idx == 4'd15) begin
                            state <= RANDOM;
                        end
                    end
                end
`endif
                RANDOM: begin
                    if (hold) begin
                        val_r <= 1'b0;
                    end else begin
                        x1_r  <= fp32_sanitize(lfsr_a_q);
                        x2_r  <= fp32_sanitize(lfsr_b_q);
                        val_r <= 1'b1;
                        cnt   <= cnt + 32'd1;
                        if (cnt == NUM_RANDOM - 32'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Terminal: en and hold are ignored until reset.
                    val_r     <= 1'b0;
                    over_r    <= !over_sent;
                    over_sent <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    val_r <= 1'b0;
                end
            endcase
        end
    end

    assign stim.x1   = x1_r;
    assign stim.x2   = x2_r;
    assign stim.val  = val_r;
    assign stim.over = over_r;
    assign state_dbg = stim_state_t'(state);

endmodule

// File: tb/tb_fp32_stim_gen.sv
// Bench for fp32_stim_gen: three instances with different seeds/lengths,
// checked against a reference vector list built from the LFSR and corner rules.
module tb_fp32_stim_gen;
    import fp32_tb_pkg::*;

    logic        clk;
    logic        rst;
    logic        en   [3];
    logic        hold [3];
    stim_state_t st   [3];
    logic [31:0] ox1  [3];
    logic [31:0] ox2  [3];
    logic        oval [3];
    logic        oover[3];

    int checks;
    int errors;

    logic [63:0] exp_q[$];

    logic [63:0] corner_ref [0:15] = '{
        64'h0000_0000_0000_0000, 64'h3F80_0000_3F80_0000,
        64'h3F80_0000_BF80_0000, 64'h7F7F_FFFF_7F7F_FFFF,
        64'h0000_0001_0000_0001, 64'h0080_0000_8000_0001,
        64'h4B80_0000_3F80_0000, 64'h3F80_0000_3380_0000,
        64'h8000_0000_0000_0000, 64'h3FFF_FFFF_3400_0000,
        64'hC120_0000_4120_0000, 64'h007F_FFFF_0000_0001,
        64'h4F00_0000_CEFF_FFFF, 64'h3F80_0001_BF80_0000,
        64'h7F00_0000_7F00_0000, 64'h3EAA_AAAB_3F2A_AAAB
    };

    fp32_stim_gen_if if0();
    fp32_stim_gen_if if1();
    fp32_stim_gen_if if2();

    fp32_stim_gen #(.NUM_RANDOM(32'd4), .SEED(32'h0000_0001)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .hold(hold[0]), .stim(if0), .state_dbg(st[0]));
    fp32_stim_gen #(.NUM_RANDOM(32'd40), .SEED(32'h7F80_0000)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .hold(hold[1]), .stim(if1), .state_dbg(st[1]));
    fp32_stim_gen #(.NUM_RANDOM(32'd30), .SEED(32'h0000_0000)) dut2 (
        .clk(clk), .rst(rst), .en(en[2]), .hold(hold[2]), .stim(if2), .state_dbg(st[2]));

    assign ox1[0] = if0.x1; assign ox2[0] = if0.x2; assign oval[0] = if0.val; assign oover[0] = if0.over;
    assign ox1[1] = if1.x1; assign ox2[1] = if1.x2; assign oval[1] = if1.val; assign oover[1] = if1.over;
    assign ox1[2] = if2.x1; assign ox2[2] = if2.x2; assign oval[2] = if2.val; assign oover[2] = if2.over;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic int num_corner();
`ifdef STIM_CORNER_EN
        return 16;
`else
        return 0;
`endif
    endfunction

    function automatic stim_state_t first_state();
`ifdef STIM_CORNER_EN
        return ST_CORNER;
`else
        return ST_RANDOM;
`endif
    endfunction

    function automatic logic [31:0] seed_of(input int k);
        case (k)
            0:       return 32'h0000_0001;
            1:       return 32'h7F80_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic int nrand_of(input int k);
        case (k)
            0:       return 4;
            1:       return 40;
            default: return 30;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        if ((s % 2) == 1) return (s / 2) ^ 32'h8020_0003;
        return s / 2;
    endfunction

    function automatic logic [31:0] finite(input logic [31:0] v);
        if (((v >> 23) & 32'hFF) == 32'hFF) return v - 32'h0080_0000;
        return v;
    endfunction

    task automatic build_exp(input int k);
        logic [31:0] a;
        logic [31:0] b;
        exp_q.delete();
        for (int i = 0; i < num_corner(); i++) exp_q.push_back(corner_ref[i]);
        a = seed_of(k);
        b = seed_of(k) ^ 32'hA5A5_A5A5;
        if (a == 0) a = 32'h1;
        if (b == 0) b = 32'h1;
        for (int i = 0; i < nrand_of(k); i++) begin
            exp_q.push_back({finite(a), finite(b)});
            a = lfsr_next(a);
            b = lfsr_next(b);
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic run_stream(input int k, input int hold_pct, input int hold_at, input string tag);
        logic [63:0] e;
        logic [31:0] last_x1;
        logic [31:0] last_x2;
        int total, seen, cyc, budget, hcnt;
        bit got_over, prev_val;
        build_exp(k);
        total = exp_q.size();
        budget = total * 4 + 50;
        seen = 0; cyc = 0; hcnt = 0; got_over = 0; prev_val = 0;
        @(negedge clk);
        en[k] = 1'b1;
        hold[k] = 1'b0;
        @(negedge clk);
        en[k] = 1'b0;
        checks++;
        if (oval[k] !== 1'b0 || oover[k] !== 1'b0)
            $display("FAIL %s start_latency k=%0d got val=%b over=%b exp 0 0", tag, k, oval[k], oover[k]);
        if (oval[k] !== 1'b0 || oover[k] !== 1'b0) errors++;
        checks++;
        if (st[k] !== first_state()) begin
            errors++;
            $display("FAIL %s start_state k=%0d got %0d exp %0d", tag, k, st[k], first_state());
        end
        last_x1 = ox1[k];
        last_x2 = ox2[k];
        while (!got_over && cyc < budget) begin
            if (hold_at >= 0 && seen == hold_at && hcnt < 3) begin
                hold[k] = 1'b1;
                hcnt++;
            end else begin
                hold[k] = (hold_pct > 0) && ($urandom_range(0, 99) < hold_pct);
            end
            @(negedge clk);
            cyc++;
            if (hold[k]) begin
                checks++;
                if (oval[k] !== 1'b0 || ox1[k] !== last_x1 || ox2[k] !== last_x2) begin
                    errors++;
                    $display("FAIL %s hold k=%0d got val=%b x=%h_%h exp val=0 x=%h_%h",
                             tag, k, oval[k], ox1[k], ox2[k], last_x1, last_x2);
                end
            end
            if (oover[k] === 1'b1) begin
                got_over = 1;
                checks++;
                if (exp_q.size() != 0 || oval[k] !== 1'b0 || !prev_val) begin
                    errors++;
                    $display("FAIL %s over_timing k=%0d got left=%0d val=%b prev_val=%b exp 0 0 1",
                             tag, k, exp_q.size(), oval[k], prev_val);
                end
            end else if (!hold[k]) begin
                checks++;
                if (oval[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s gap k=%0d cyc=%0d got val=%b exp 1", tag, k, cyc, oval[k]);
                end
            end
            if (oval[k] === 1'b1) begin
                seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_vec k=%0d got %h_%h exp none", tag, k, ox1[k], ox2[k]);
                end else begin
                    e = exp_q.pop_front();
                    if ({ox1[k], ox2[k]} !== e) begin
                        errors++;
                        $display("FAIL %s vec k=%0d n=%0d got %h_%h exp %h_%h",
                                 tag, k, seen - 1, ox1[k], ox2[k], e[63:32], e[31:0]);
                    end
                end
                checks++;
                if (ox1[k][30:23] == 8'hFF || ox2[k][30:23] == 8'hFF) begin
                    errors++;
                    $display("FAIL %s nan_inf k=%0d got %h_%h exp finite", tag, k, ox1[k], ox2[k]);
                end
            end
            prev_val = oval[k];
            last_x1 = ox1[k];
            last_x2 = ox2[k];
        end
        hold[k] = 1'b0;
        checks++;
        if (!got_over) begin
            errors++;
            $display("FAIL %s timeout k=%0d got no over in %0d cycles exp over", tag, k, budget);
        end
        checks++;
        if (seen != total) begin
            errors++;
            $display("FAIL %s count k=%0d got %0d exp %0d", tag, k, seen, total);
        end
        // After the pulse: terminal, silent, en ignored, for as long as the checker lags.
        for (int i = 0; i < ADDER_LATENCY + 2; i++) begin
            en[k] = (i == 1);
            hold[k] = (i == 3);
            @(negedge clk);
            checks++;
            if (oval[k] !== 1'b0 || oover[k] !== 1'b0 || st[k] !== ST_DONE) begin
                errors++;
                $display("FAIL %s post_done k=%0d i=%0d got val=%b over=%b st=%0d exp 0 0 %0d",
                         tag, k, i, oval[k], oover[k], st[k], ST_DONE);
            end
        end
        en[k] = 1'b0;
        hold[k] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0;
            hold[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ox1[k] !== 32'd0 || ox2[k] !== 32'd0 || oval[k] !== 1'b0 ||
                oover[k] !== 1'b0 || st[k] !== ST_IDLE) begin
                errors++;
                $display("FAIL reset k=%0d got x=%h_%h val=%b over=%b st=%0d exp zeros idle",
                         k, ox1[k], ox2[k], oval[k], oover[k], st[k]);
            end
        end
        rst = 1'b1;
        // Idle with en low must stay idle.
        repeat (3) @(negedge clk);
        checks++;
        if (oval[0] !== 1'b0 || st[0] !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_wait got val=%b st=%0d exp 0 %0d", oval[0], st[0], ST_IDLE);
        end
    endtask

    task automatic test_corner_random();
        run_stream(0, 0, -1, "corner_random");
    endtask

    task automatic test_exp_sanitize();
        run_stream(1, 0, -1, "sanitize");
    endtask

    task automatic test_hold();
        do_reset();
        run_stream(1, 0, 5, "hold_directed");
        do_reset();
        run_stream(0, 35, -1, "hold_random");
    endtask

    task automatic test_seed_zero();
        run_stream(2, 20, -1, "seed_zero");
    endtask

    task automatic test_reset_midrun();
        int seen, cyc, target;
        do_reset();
        target = num_corner() + 3;
        seen = 0;
        cyc = 0;
        @(negedge clk);
        en[1] = 1'b1;
        @(negedge clk);
        en[1] = 1'b0;
        while (seen < target && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (oval[1] === 1'b1) seen++;
        end
        checks++;
        if (seen < target) begin
            errors++;
            $display("FAIL midrun_reach got %0d exp %0d", seen, target);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ox1[1] !== 32'd0 || ox2[1] !== 32'd0 || oval[1] !== 1'b0 ||
            oover[1] !== 1'b0 || st[1] !== ST_IDLE) begin
            errors++;
            $display("FAIL midrun_async got x=%h_%h val=%b over=%b st=%0d exp zeros idle",
                     ox1[1], ox2[1], oval[1], oover[1], st[1]);
        end
        @(negedge clk);
        rst = 1'b1;
        run_stream(1, 0, -1, "rerun");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        test_reset();
        test_corner_random();
        test_exp_sanitize();
        test_hold();
        test_seed_zero();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
